// File: rtl/deck_shuffler_if.sv
// Control handshake and single-port deck RAM bus of deck_shuffler.
// The shuffler attaches through the slave modport; the game controller/RAM side uses master.
interface deck_shuffler_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4,
  parameter int LFSR_W = 16
);
  logic              i_Start;
  logic              i_SeedLoad;
  logic [LFSR_W-1:0] i_Seed;
  logic [DATA_W-1:0] i_MemRdData;
  logic [ADDR_W-1:0] o_MemAddr;
  logic [DATA_W-1:0] o_MemWrData;
  logic              o_MemEn;
  logic              o_MemWe;
  logic              o_Busy;
  logic              o_Done;
  logic              o_Shuffled;

  modport slave (
    input  i_Start, i_SeedLoad, i_Seed, i_MemRdData,
    output o_MemAddr, o_MemWrData, o_MemEn, o_MemWe, o_Busy, o_Done, o_Shuffled
  );

  modport master (
    output i_Start, i_SeedLoad, i_Seed, i_MemRdData,
    input  o_MemAddr, o_MemWrData, o_MemEn, o_MemWe, o_Busy, o_Done, o_Shuffled
  );
endinterface

// File: rtl/deck_shuffler.sv
// In-place Fisher-Yates shuffler for a single-port deck RAM, indices drawn from a Galois LFSR.
// Optional feature: define DECK_INIT_EN to pre-fill the deck with (k % RANKS)+1 before shuffling.
module deck_shuffler #(
  parameter int                DECK_SIZE = 52,
  parameter int                DATA_W    = 4,
  parameter int                ADDR_W    = 6,
  parameter int                RANKS     = 13,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY = 16'hB400
) (
  input  logic           clk,
  input  logic           i_RstN,
  deck_shuffler_if.slave bus
);

  if (DECK_SIZE < 2 || (1 << ADDR_W) < DECK_SIZE || LFSR_W < ADDR_W ||
      RANKS < 1 || RANKS > (1 << DATA_W) - 1) begin : g_param_check
    $error("deck_shuffler: inconsistent parameter set");
  end

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DECK_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef DECK_INIT_EN
    S_INIT,
`endif
    S_PICK,
    S_RD_I,
    S_RD_J,
    S_WR_J,
    S_WR_I,
    S_DONE
  } state_t;

  // Smallest all-ones value that covers idx, so candidates are uniform over [0, mask].
  function automatic logic [ADDR_W-1:0] mask_for(input logic [ADDR_W-1:0] idx);
    logic [ADDR_W-1:0] m;
    m = idx;
    for (int s = 1; s < ADDR_W; s = s * 2) m = m | (m >> s);
    return m;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [DATA_W-1:0] data_i_q, data_i_d;
  logic [DATA_W-1:0] data_j_q, data_j_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              shuffled_q, shuffled_d;
`ifdef DECK_INIT_EN
  logic [ADDR_W-1:0] k_q, k_d;
  logic [DATA_W-1:0] rank_q, rank_d;
`endif

  logic [ADDR_W-1:0] cand;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_en;
  logic              mem_we;

  // NOTE: every variable gets a default before the case; a path that leaves one unassigned infers a latch.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_step(lfsr_q);
    i_d         = i_q;
    j_d         = j_q;
    data_i_d    = data_i_q;
    data_j_d    = data_j_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    shuffled_d  = shuffled_q;
`ifdef DECK_INIT_EN
    k_d         = k_q;
    rank_d      = rank_q;
`endif
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    cand        = lfsr_q[ADDR_W-1:0] & mask_for(i_q);

    case (state_q)
      S_IDLE: begin
        if (bus.i_SeedLoad) begin
          lfsr_d = (bus.i_Seed == '0) ? LFSR_W'(1) : bus.i_Seed;
        end else if (bus.i_Start) begin
          i_d        = LAST_IDX;
          shuffled_d = 1'b0;
          busy_d     = 1'b1;
`ifdef DECK_INIT_EN
          k_d        = '0;
          rank_d     = DATA_W'(1);
          state_d    = S_INIT;
`else
          state_d    = S_PICK;
`endif
        end
      end

`ifdef DECK_INIT_EN
      S_INIT: begin
        mem_en      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = k_q;
        mem_wr_data = rank_q;
        k_d         = k_q + ADDR_W'(1);
        rank_d      = (rank_q == DATA_W'(RANKS)) ? DATA_W'(1) : rank_q + DATA_W'(1);
        if (k_q == LAST_IDX) state_d = S_PICK;
      end
`endif

      // Rejection sampling: out-of-range candidates are retried with the next LFSR value.
      S_PICK: begin
        if (cand <= i_q) begin
          j_d     = cand;
          state_d = S_RD_I;
        end
      end

      S_RD_I: begin
        mem_en   = 1'b1;
        mem_addr = i_q;
        state_d  = S_RD_J;
      end

      S_RD_J: begin
        mem_en   = 1'b1;
        mem_addr = j_q;
        data_i_d = bus.i_MemRdData;
        state_d  = S_WR_J;
      end

      S_WR_J: begin
        mem_en      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = j_q;
        mem_wr_data = data_i_q;
        data_j_d    = bus.i_MemRdData;
        state_d     = S_WR_I;
      end

      // i stops at 1, so the index never wraps below zero.
      S_WR_I: begin
        mem_en      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = i_q;
        mem_wr_data = data_j_q;
        if (i_q == ADDR_W'(1)) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q - ADDR_W'(1);
          state_d = S_PICK;
        end
      end

      S_DONE: begin
        done_d     = 1'b1;
        shuffled_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge i_RstN) begin
    if (!i_RstN) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_W'(1);
      i_q        <= '0;
      j_q        <= '0;
      data_i_q   <= '0;
      data_j_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shuffled_q <= 1'b0;
`ifdef DECK_INIT_EN
      k_q        <= '0;
      rank_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      i_q        <= i_d;
      j_q        <= j_d;
      data_i_q   <= data_i_d;
      data_j_q   <= data_j_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      shuffled_q <= shuffled_d;
`ifdef DECK_INIT_EN
      k_q        <= k_d;
      rank_q     <= rank_d;
`endif
    end
  end

  assign bus.o_MemAddr   = mem_addr;
  assign bus.o_MemWrData = mem_wr_data;
  assign bus.o_MemEn     = mem_en;
  assign bus.o_MemWe     = mem_we;
  assign bus.o_Busy      = busy_q;
  assign bus.o_Done      = done_q;
  assign bus.o_Shuffled  = shuffled_q;

endmodule

// File: tb/tb_deck_shuffler.sv
// Bench for deck_shuffler: a 52-entry and a 4-entry instance on behavioural RAMs, checked
// against a Fisher-Yates reference model that also accounts LFSR steps per clock.
`timescale 1ns/1ps
module tb_deck_shuffler;
  localparam int          N    = 52;
  localparam int          NS   = 4;
  localparam logic [15:0] POLY = 16'hB400;

  logic       clk = 1'b0;
  logic       rst_n;
  int         tests = 0;
  int         fails = 0;
  int         run_id = 0;
  int         done_cnt = 0;
  int         done_cnt_s = 0;
  logic       ram_load = 1'b0;
  logic [3:0] ram   [64];
  logic [3:0] ram_s [NS];
  int         mdl   [64];
  int         hist_before [16];

  always #5 clk = ~clk;

  deck_shuffler_if #(.ADDR_W(6), .DATA_W(4), .LFSR_W(16)) bus ();
  deck_shuffler_if #(.ADDR_W(2), .DATA_W(4), .LFSR_W(16)) bus_s ();

  deck_shuffler #(.DECK_SIZE(N), .DATA_W(4), .ADDR_W(6), .RANKS(13), .LFSR_W(16),
                  .LFSR_POLY(POLY)) dut (.clk(clk), .i_RstN(rst_n), .bus(bus));
  deck_shuffler #(.DECK_SIZE(NS), .DATA_W(4), .ADDR_W(2), .RANKS(13), .LFSR_W(16),
                  .LFSR_POLY(POLY)) dut_s (.clk(clk), .i_RstN(rst_n), .bus(bus_s));

  // Single-port RAMs with one cycle of read latency; a load pulse fills a card-deck image.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int k = 0; k < 64; k++) ram[k] <= 4'((k % 13) + 1);
      for (int k = 0; k < NS; k++) ram_s[k] <= 4'(k + 1);
    end else begin
      if (bus.o_MemEn === 1'b1) begin
        if (bus.o_MemWe) ram[bus.o_MemAddr] <= bus.o_MemWrData;
        else             bus.i_MemRdData <= ram[bus.o_MemAddr];
      end
      if (bus_s.o_MemEn === 1'b1) begin
        if (bus_s.o_MemWe) ram_s[bus_s.o_MemAddr] <= bus_s.o_MemWrData;
        else               bus_s.i_MemRdData <= ram_s[bus_s.o_MemAddr];
      end
    end
  end

  always @(negedge clk) begin
    if (bus.o_Done === 1'b1)   done_cnt   <= done_cnt + 1;
    if (bus_s.o_Done === 1'b1) done_cnt_s <= done_cnt_s + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s (run %0d): observed=%0h expected=%0h", tag, run_id, got, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    logic lsb;
    lsb = v[0];
    v = v >> 1;
    if (lsb) v = v ^ POLY;
    return v;
  endfunction

  // Shuffles mdl[0..n-1] as the spec describes and returns the start-to-o_Done cycle count,
  // assuming the seed is loaded the cycle before start is asserted.
  function automatic int model_shuffle(input int n, input logic [15:0] seed);
    logic [15:0] v;
    int cyc, m, cand, t;
    v   = (seed == 16'h0) ? 16'h1 : seed;
    v   = step(v);
    cyc = 2;
`ifdef DECK_INIT_EN
    for (int k = 0; k < n; k++) mdl[k] = (k % 13) + 1;
    for (int k = 0; k < n; k++) v = step(v);
    cyc += n;
`endif
    for (int i = n - 1; i >= 1; i--) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      do begin
        cand = int'(v) & m;
        v    = step(v);
        cyc++;
      end while (cand > i);
      for (int s = 0; s < 4; s++) v = step(v);
      cyc += 4;
      t = mdl[i]; mdl[i] = mdl[cand]; mdl[cand] = t;
    end
    return cyc;
  endfunction

  function automatic void save_hist();
    foreach (hist_before[v]) hist_before[v] = 0;
    for (int k = 0; k < N; k++) hist_before[ram[k]]++;
  endfunction

  function automatic int perm_diff();
    int h [16];
    int d;
    foreach (h[v]) h[v] = 0;
    for (int k = 0; k < N; k++) h[ram[k]]++;
    d = 0;
    foreach (h[v]) if (h[v] != hist_before[v]) d++;
    return d;
  endfunction

  task automatic run_shuffle(input logic [15:0] seed, input bit pulse, input bit both);
    int exp_lat, lat, d0, mism;
    bit seen;
    run_id++;
    for (int k = 0; k < N; k++) mdl[k] = int'(ram[k]);
    save_hist();
    exp_lat = model_shuffle(N, seed);
    @(posedge clk); #1;
    bus.i_SeedLoad = 1'b1; bus.i_Seed = seed; bus.i_Start = both;
    @(posedge clk); #1;
    bus.i_SeedLoad = 1'b0; bus.i_Start = 1'b1;
    @(negedge clk);
    check("idle_before_start", bus.o_Busy, 1'b0);
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    d0 = done_cnt; lat = 0; seen = 1'b0;
    while (!seen && lat < 5000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("busy_after_start", bus.o_Busy, 1'b1);
        check("shuffled_cleared", bus.o_Shuffled, 1'b0);
      end
      if (bus.o_Done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        bus.i_Start = pulse && (bus.o_Busy === 1'b1) && ($urandom_range(0, 1) == 1);
      end
    end
    bus.i_Start = 1'b0;
    check("done_seen", seen, 1'b1);
    check("latency", lat, exp_lat);
    check("shuffled_set", bus.o_Shuffled, 1'b1);
    check("busy_at_done", bus.o_Busy, 1'b0);
    repeat (3) @(negedge clk);
    check("done_count", done_cnt - d0, 1);
    mism = 0;
    for (int k = 0; k < N; k++) if (int'(ram[k]) != mdl[k]) mism++;
    check("ram_vs_model", mism, 0);
    check("permutation", perm_diff(), 0);
  endtask

  task automatic reset_mid_shuffle(input logic [15:0] seed);
    int waited;
    run_id++;
    save_hist();
    @(posedge clk); #1;
    bus.i_SeedLoad = 1'b1; bus.i_Seed = seed; bus.i_Start = 1'b0;
    @(posedge clk); #1;
    bus.i_SeedLoad = 1'b0; bus.i_Start = 1'b1;
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    waited = 0;
    while (bus.o_MemEn !== 1'b0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("reset_window_busy", bus.o_Busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.o_Busy, 1'b0);
    check("rst_done", bus.o_Done, 1'b0);
    check("rst_shuffled", bus.o_Shuffled, 1'b0);
    check("rst_mem_en", bus.o_MemEn, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("perm_after_reset", perm_diff(), 0);
  endtask

  initial begin
    int  lat, exp_lat, mism;
    bit  seen;
    rst_n = 1'b0;
    bus.i_Start = 1'b0;   bus.i_SeedLoad = 1'b0;   bus.i_Seed = 16'h0;
    bus_s.i_Start = 1'b0; bus_s.i_SeedLoad = 1'b0; bus_s.i_Seed = 16'h0;
    ram_load = 1'b1;
    @(negedge clk);
    check("reset_busy", bus.o_Busy, 1'b0);
    check("reset_done", bus.o_Done, 1'b0);
    check("reset_shuffled", bus.o_Shuffled, 1'b0);
    check("reset_mem_en", bus.o_MemEn, 1'b0);
    check("reset_small_busy", bus_s.o_Busy, 1'b0);
    @(posedge clk); #1;
    ram_load = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Four-entry deck, seed 16'hACE1: exact final image and latency.
    run_id++;
    for (int k = 0; k < NS; k++) mdl[k] = k + 1;
    exp_lat = model_shuffle(NS, 16'hACE1);
    @(posedge clk); #1;
    bus_s.i_SeedLoad = 1'b1; bus_s.i_Seed = 16'hACE1;
    @(posedge clk); #1;
    bus_s.i_SeedLoad = 1'b0; bus_s.i_Start = 1'b1;
    @(posedge clk); #1;
    bus_s.i_Start = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (bus_s.o_Done === 1'b1) seen = 1'b1;
    end
    check("small_done_seen", seen, 1'b1);
    check("small_latency", lat, exp_lat);
    repeat (3) @(negedge clk);
    check("small_done_count", done_cnt_s, 1);
    mism = 0;
    for (int k = 0; k < NS; k++) if (int'(ram_s[k]) != mdl[k]) mism++;
    check("small_ram_vs_model", mism, 0);

    run_shuffle(16'hACE1, 1'b0, 1'b0);
    run_shuffle(16'h0000, 1'b0, 1'b0);
    run_shuffle(16'($urandom), 1'b0, 1'b1);
    run_shuffle(16'($urandom), 1'b1, 1'b0);
    reset_mid_shuffle(16'($urandom));
    run_shuffle(16'($urandom), 1'b0, 1'b0);
    for (int r = 0; r < 100; r++) run_shuffle(16'($urandom), (r % 5) == 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
